// File: rtl/burst_write_beat_gen_pkg.sv
// Shared definitions for the AXI write-path burst beat generator and its splitter/realigner neighbours.
package burst_write_beat_gen_pkg;

  function automatic int calculate_AXI_OFFSET_W(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_DATA  = 2'd2
  } bwg_state_e;

endpackage

// File: rtl/burst_strobe_mask.sv
// First/last byte-lane masks of a burst starting at byte lane `offset` and spanning `byte_len` bytes.
module burst_strobe_mask
  import burst_write_beat_gen_pkg::*;
#(
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 16,
  localparam int B         = AXI_DATA_W / 8,
  localparam int OFFSET_W  = calculate_AXI_OFFSET_W(AXI_DATA_W)
) (
  input  logic [OFFSET_W-1:0] offset,
  input  logic [LEN_W-1:0]    byte_len,
  output logic [LEN_W:0]      end_bytes,
  output logic [B-1:0]        first_mask,
  output logic [B-1:0]        last_mask
);

  localparam logic [B-1:0] ONES = '1;

  logic [OFFSET_W-1:0] end_lane;
  logic [OFFSET_W-1:0] tail_shift;

  always_comb begin
    // One bit wider than byte_len so a maximum-length burst cannot wrap.
    end_bytes  = {1'b0, byte_len} + {{(LEN_W + 1 - OFFSET_W){1'b0}}, offset};
    end_lane   = end_bytes[OFFSET_W-1:0];
    // (B - end_lane) mod B is the two's complement of end_lane in OFFSET_W bits.
    tail_shift = (~end_lane) + {{(OFFSET_W - 1){1'b0}}, 1'b1};
    first_mask = ONES << offset;
    last_mask  = ONES >> tail_shift;
  end

endmodule

// File: rtl/burst_write_beat_gen.sv
// Drives the byte-offset splitter and emits AXI W beats (WSTRB/WLAST) for one burst at a time.
module burst_write_beat_gen
  import burst_write_beat_gen_pkg::*;
#(
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 16,
  localparam int OFFSET_W  = calculate_AXI_OFFSET_W(AXI_DATA_W)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OFFSET_W-1:0]     offset,
  input  logic [LEN_W-1:0]        byte_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    in_valid,
  output logic                    in_pop,
  output logic                    split_first,
  output logic                    split_adv,
  input  logic [AXI_DATA_W-1:0]   split_data,
  output logic [AXI_DATA_W-1:0]   wdata,
  output logic [AXI_DATA_W/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready
);

  localparam int B     = AXI_DATA_W / 8;
  localparam int CNT_W = LEN_W + 1;
  localparam logic [B-1:0]     ONES    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] ROUND   = CNT_W'(B - 1);

  bwg_state_e       state_q, state_d;
  logic [CNT_W-1:0] beats_q, beats_d;
  logic [CNT_W-1:0] in_words_q, in_words_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] words_loaded_q, words_loaded_d;
  logic [CNT_W-1:0] beats_loaded_q, beats_loaded_d;
  logic [B-1:0]     first_mask_q, first_mask_d;
  logic [B-1:0]     last_mask_q, last_mask_d;
  logic             out_full_q, out_full_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] end_bytes;
  logic [B-1:0]     first_mask_w, last_mask_w;
  logic             is_last, hs, load, need_in;

  // Masks are evaluated on the live request and captured when the burst is accepted.
  burst_strobe_mask #(
    .AXI_DATA_W (AXI_DATA_W),
    .LEN_W      (LEN_W)
  ) u_mask (
    .offset     (offset),
    .byte_len   (byte_len),
    .end_bytes  (end_bytes),
    .first_mask (first_mask_w),
    .last_mask  (last_mask_w)
  );

  assign is_last = (beat_cnt_q == beats_q - CNT_ONE);

  always_comb begin
    state_d        = state_q;
    beats_d        = beats_q;
    in_words_d     = in_words_q;
    beat_cnt_d     = beat_cnt_q;
    words_loaded_d = words_loaded_q;
    beats_loaded_d = beats_loaded_q;
    first_mask_d   = first_mask_q;
    last_mask_d    = last_mask_q;
    out_full_d     = out_full_q;
    done_d         = 1'b0;
    in_pop         = 1'b0;
    split_first    = 1'b0;
    split_adv      = 1'b0;
    wvalid         = 1'b0;
    hs             = 1'b0;
    load           = 1'b0;
    need_in        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (byte_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d      = ST_PRIME;
            beats_d      = (end_bytes + ROUND) >> OFFSET_W;
            in_words_d   = ({1'b0, byte_len} + ROUND) >> OFFSET_W;
            first_mask_d = first_mask_w;
            last_mask_d  = last_mask_w;
          end
        end
      end

      ST_PRIME: begin
        split_first = in_valid;
        in_pop      = in_valid;
        if (in_valid) begin
          state_d        = ST_DATA;
          out_full_d     = 1'b1;
          beat_cnt_d     = '0;
          words_loaded_d = CNT_ONE;
          beats_loaded_d = CNT_ONE;
        end
      end

      ST_DATA: begin
        wvalid  = out_full_q;
        hs      = wvalid & wready;
        // Refill the splitter output whenever it is empty or is being drained by a non-final beat.
        load    = !out_full_q || (hs && !is_last);
        need_in = (words_loaded_q < in_words_q);
        // The trailing offset beat needs no new word: it is flushed from splitter storage.
        split_adv = load && (in_valid || !need_in) && (beats_loaded_q < beats_q);
        in_pop    = split_adv && need_in;
        if (split_adv) begin
          out_full_d     = 1'b1;
          words_loaded_d = words_loaded_q + CNT_W'(need_in);
          beats_loaded_d = beats_loaded_q + CNT_ONE;
        end else if (hs) begin
          out_full_d = 1'b0;
        end
        if (hs) begin
          beat_cnt_d = beat_cnt_q + CNT_ONE;
          if (is_last) begin
            state_d    = ST_IDLE;
            out_full_d = 1'b0;
            done_d     = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      beats_q        <= '0;
      in_words_q     <= '0;
      beat_cnt_q     <= '0;
      words_loaded_q <= '0;
      beats_loaded_q <= '0;
      first_mask_q   <= '0;
      last_mask_q    <= '0;
      out_full_q     <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      beats_q        <= beats_d;
      in_words_q     <= in_words_d;
      beat_cnt_q     <= beat_cnt_d;
      words_loaded_q <= words_loaded_d;
      beats_loaded_q <= beats_loaded_d;
      first_mask_q   <= first_mask_d;
      last_mask_q    <= last_mask_d;
      out_full_q     <= out_full_d;
      done_q         <= done_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign wdata = split_data;
  assign wlast = wvalid & is_last;
  assign wstrb = wvalid ? (((beat_cnt_q == '0) ? first_mask_q : ONES) &
                           (is_last ? last_mask_q : ONES)) : '0;

endmodule

// File: tb/tb_burst_write_beat_gen.sv
// Directed bench for burst_write_beat_gen with a simple splitter model and a beat scoreboard.
module tb_burst_write_beat_gen;

  localparam int DW    = 32;
  localparam int LEN_W = 16;
  localparam int B     = DW / 8;
  localparam int OW    = 2;
  localparam int EW    = DW + B + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [OW-1:0]    offset;
  logic [LEN_W-1:0] byte_len;
  logic             busy, done;
  logic             in_valid, in_pop;
  logic             split_first, split_adv;
  logic [DW-1:0]    split_data;
  logic [DW-1:0]    wdata;
  logic [B-1:0]     wstrb;
  logic             wlast, wvalid, wready;

  int compared   = 0;
  int mismatched = 0;
  logic [EW-1:0] exp_q[$];

  int cyc = 0;
  int hs_cnt, pop_cnt, done_cnt, first_wv_cyc;
  int fifo_words, stall_beat, stall_cyc, stalled;
  logic [15:0] bid;
  logic [15:0] ld_idx;

  burst_write_beat_gen #(.AXI_DATA_W(DW), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .offset(offset), .byte_len(byte_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_pop(in_pop),
    .split_first(split_first), .split_adv(split_adv), .split_data(split_data),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Splitter model: each load presents {burst id, load index}.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      split_data <= '0;
      ld_idx     <= '0;
    end else if (split_first) begin
      split_data <= {bid, 16'h0000};
      ld_idx     <= 16'd1;
    end else if (split_adv) begin
      split_data <= {bid, ld_idx};
      ld_idx     <= ld_idx + 16'd1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    logic          held_v;
    logic [EW-1:0] held_val;
    logic [EW-1:0] cur;
    held_v = 1'b0;
    held_val = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held_v = 1'b0;
      end else begin
        cur = {wdata, wstrb, wlast};
        if (held_v) begin
          check("stall_wvalid", 64'(wvalid), 64'd1);
          check("stall_hold", 64'(cur), 64'(held_val));
        end
        if (wvalid && !wready) begin
          check("adv_while_stalled", 64'(split_adv), 64'd0);
          held_v   = 1'b1;
          held_val = cur;
        end else begin
          held_v = 1'b0;
        end
        if (wvalid && first_wv_cyc < 0) first_wv_cyc = cyc;
        if (wvalid && wready) begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_beat: got %0h, required no beat", cur);
          end else begin
            check("beat", 64'(cur), 64'(exp_q.pop_front()));
          end
          hs_cnt++;
        end
        if (in_pop) pop_cnt++;
        if (done) done_cnt++;
      end
    end
  end

  // Driver: one cycle step; FIFO model holds fifo_words words, optional stall on one beat.
  task automatic tick();
    @(posedge clk);
    #1;
    in_valid = (pop_cnt < fifo_words);
    wready   = !(wvalid && hs_cnt == stall_beat && stalled < stall_cyc);
    if (!wready) stalled++;
  endtask

  task automatic run_burst(input int off, input int len, input int nb,
                           input logic [3:0] s0, input logic [3:0] s1,
                           input logic [3:0] s2, input logic [3:0] s3,
                           input int pops, input int sbeat, input int scyc,
                           input bit extra_start);
    logic [3:0] s [4];
    int c0;
    s = '{s0, s1, s2, s3};
    bid          = bid + 16'd1;
    fifo_words   = pops;
    stall_beat   = sbeat;
    stall_cyc    = scyc;
    stalled      = 0;
    hs_cnt       = 0;
    pop_cnt      = 0;
    done_cnt     = 0;
    first_wv_cyc = -1;
    for (int k = 0; k < nb; k++)
      exp_q.push_back({bid, 16'(k), s[k], (k == nb - 1)});
    @(posedge clk);
    #1;
    offset   = OW'(off);
    byte_len = LEN_W'(len);
    start    = 1'b1;
    in_valid = (fifo_words > 0);
    wready   = 1'b1;
    c0       = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 300 && done_cnt == 0; i++) begin
      if (extra_start && i == 1) begin
        start    = 1'b1;
        offset   = 2'd0;
        byte_len = 16'd4;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    if (done_cnt == 0) begin
      compared++;
      mismatched++;
      $display("FAIL done_timeout: got no done, required done (off=%0d len=%0d)", off, len);
    end
    tick(); tick(); tick();
    check("done_pulses", 64'(done_cnt), 64'd1);
    check("beat_count", 64'(hs_cnt), 64'(nb));
    check("pop_count", 64'(pop_cnt), 64'(pops));
    check("exp_left", 64'(exp_q.size()), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("first_latency", 64'(first_wv_cyc - c0), 64'd2);
    exp_q.delete();
  endtask

  task automatic zero_len();
    done_cnt = 0;
    hs_cnt   = 0;
    @(posedge clk);
    #1;
    offset   = 2'd2;
    byte_len = 16'd0;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_wvalid", 64'(wvalid), 64'd0);
    check("zero_done_count", 64'(done_cnt), 64'd1);
    check("zero_beats", 64'(hs_cnt), 64'd0);
  endtask

  task automatic reset_mid_burst();
    int hs_at_rst;
    bid        = bid + 16'd1;
    fifo_words = 4;
    stall_beat = -1;
    stall_cyc  = 0;
    hs_cnt     = 0;
    pop_cnt    = 0;
    done_cnt   = 0;
    for (int k = 0; k < 4; k++) exp_q.push_back({bid, 16'(k), 4'hF, (k == 3)});
    @(posedge clk);
    #1;
    offset   = 2'd0;
    byte_len = 16'd16;
    start    = 1'b1;
    in_valid = 1'b1;
    wready   = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 50 && hs_cnt < 1; i++) tick();
    check("rst_reached_beat1", 64'(hs_cnt >= 1), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wvalid", 64'(wvalid), 64'd0);
    check("rst_misc", 64'({wlast, wstrb, split_first, split_adv, in_pop, done}), 64'd0);
    exp_q.delete();
    fifo_words = 0;
    hs_at_rst  = hs_cnt;
    done_cnt   = 0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("rst_no_done", 64'(done_cnt), 64'd0);
    check("rst_no_resume", 64'(hs_cnt), 64'(hs_at_rst));
    check("rst_idle", 64'(busy), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got time limit, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    rst        = 1'b1;
    start      = 1'b0;
    offset     = '0;
    byte_len   = '0;
    in_valid   = 1'b0;
    wready     = 1'b1;
    bid        = 16'h00A0;
    fifo_words = 0;
    stall_beat = -1;
    stall_cyc  = 0;
    stalled    = 0;
    hs_cnt     = 0;
    pop_cnt    = 0;
    done_cnt   = 0;
    first_wv_cyc = -1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_outputs", 64'({done, wvalid, wlast, wstrb, split_first, split_adv, in_pop}), 64'd0);
    rst = 1'b0;
    tick();

    // offset 0, 8 bytes, plus a start while busy that must be ignored
    run_burst(0, 8, 2, 4'hF, 4'hF, 4'h0, 4'h0, 2, -1, 0, 1'b1);
    // offset 1, 8 bytes: third beat flushed without a pop
    run_burst(1, 8, 3, 4'hE, 4'hF, 4'h1, 4'h0, 2, -1, 0, 1'b0);
    // single byte in the top lane
    run_burst(3, 1, 1, 4'h8, 4'h0, 4'h0, 4'h0, 1, -1, 0, 1'b0);
    // offset 2, 4 bytes, beat 0 stalled 3 cycles
    run_burst(2, 4, 2, 4'hC, 4'h3, 4'h0, 4'h0, 1, 0, 3, 1'b0);
    zero_len();
    reset_mid_burst();
    // fresh burst after reset: offset 2, 9 bytes, beat 1 stalled 2 cycles
    run_burst(2, 9, 3, 4'hC, 4'hF, 4'h7, 4'h0, 3, 1, 2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/burst_write_beat_gen.md
Name: burst_write_beat_gen

Overview:
Downstream neighbour of the byte-offset burst splitter on the AXI write path.
- Controls the splitter's load and advance strobes.
- Counts write beats and emits AXI W-channel beats with correct WSTRB on the partial first and last beats, plus WLAST.
- Pops aligned words from the upstream FIFO only when the splitter actually consumes new input. The final offset-induced beat is flushed from splitter storage without a pop.
- The AW channel is issued elsewhere; this block handles W beats only.

Parameters:
AXI_DATA_W, 32, W data width in bits; legal values 16, 32, 64.
LEN_W, 16, width of the byte-length input.
OFFSET_W, calculate_AXI_OFFSET_W(AXI_DATA_W), localparam; log2 of bytes per word.

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  reset, asynchronous, active-high.
start  in  1  one-cycle request; sampled only in IDLE.
offset  in  OFFSET_W  start byte lane of the burst; also wired to the splitter offset.
byte_len  in  LEN_W  total bytes to write.
busy  out  1  high while not IDLE.
done  out  1  one-cycle pulse after the last beat handshake, or after a zero-length start.
in_valid  in  1  upstream FIFO holds an aligned word.
in_pop  out  1  upstream FIFO pop; combinational.
split_first  out  1  drives splitter firstValid.
split_adv  out  1  drives splitter ready_out.
split_data  in  AXI_DATA_W  splitter data_out.
wdata  out  AXI_DATA_W  equals split_data.
wstrb  out  AXI_DATA_W/8  byte strobes.
wlast  out  1  marks the last beat.
wvalid  out  1  AXI valid.
wready  in  1  AXI ready.

Behaviour:
- Reset: state=IDLE. busy, done, wvalid, wlast, split_first, split_adv, in_pop = 0. wstrb=0. Counters cleared.
- Reset mid-burst aborts immediately. No beats resume afterwards, and done is not pulsed.
- Definitions, with B = AXI_DATA_W/8:
  - in_words = ceil(byte_len/B).
  - beats = ceil((offset+byte_len)/B). beats is either in_words or in_words+1.
  - offset, beats and in_words are registered at start.
- IDLE:
  - start with byte_len=0: remain IDLE; done=1 on the next cycle; no beats.
  - start with byte_len>0: go to PRIME.
  - start while busy: ignored.
- PRIME:
  - split_first = in_valid and in_pop = in_valid.
  - On in_valid: go to DATA with out_full=1, beat_cnt=0, words_loaded=1.
- DATA:
  - wvalid = out_full. Handshake hs = wvalid & wready.
  - load = out_full==0 or (hs and beat_cnt != beats-1).
  - need_in = words_loaded < in_words.
  - split_adv = load & (in_valid | !need_in) & (beats_loaded < beats).
  - in_pop = split_adv & need_in.
  - On split_adv: out_full=1, words_loaded += need_in, beats_loaded++.
  - Else on hs: out_full=0.
  - On hs: beat_cnt++.
  - On hs with beat_cnt = beats-1: go to IDLE and pulse done the next cycle.
- Strobes:
  - first_mask = all-ones << offset.
  - last_mask = all-ones >> ((B - ((offset+byte_len) mod B)) mod B).
  - wstrb = (beat_cnt==0 ? first_mask : all-ones) & (wlast ? last_mask : all-ones).
  - wlast = (beat_cnt == beats-1).
- AXI rules:
  - While wvalid=1 and wready=0: wdata, wstrb and wlast are held stable, and split_adv=0.
  - wvalid never drops without a handshake.
- Throughput: one beat per cycle with wready and in_valid held high. Latency from start to first wvalid is 2 cycles, given in_valid.
- Arithmetic: offset+byte_len is computed in LEN_W+1 bits, so there is no wrap at maximum length.

Decomposition:
- Shared package: calculate_AXI_OFFSET_W (already shared with the splitter) and the IDLE/PRIME/DATA state encoding.
- One natural sub-module, burst_strobe_mask: combinational first and last masks from offset, byte_len and AXI_DATA_W. It is reused by the read-side realigner.

Test Plan:
- AXI_DATA_W=32, offset=0, len=8, wready=1 -> 2 beats; wstrb F,F; wlast on beat 2; 2 pops; done pulses.
- offset=1, len=8 -> 3 beats; wstrb E,F,1; exactly 2 in_pops; the third beat is flushed with in_valid=0.
- offset=3, len=1 -> 1 beat; wstrb=8; wlast=1 on the first beat.
- offset=2, len=4, wready low for 3 cycles on beat 0 -> wdata, wstrb=C and wlast stable; no split_adv while stalled; beat 2 wstrb=3.
- start with len=0 -> no wvalid; done one cycle later; start asserted while busy -> ignored.
- rst asserted after beat 1 of a 4-beat burst -> all outputs 0 immediately; no done; a fresh start then works normally.
